// File: rtl/pc_cmd_frame_gen_if.sv
// Command-FIFO and read-FIFO signal bundle for pc_cmd_frame_gen.
// master is the frame generator's side; slave is the FIFO/host side.
interface pc_cmd_frame_gen_if;
   logic [31:0] cmd_data;
   logic        cmd_empty;
   logic        cmd_ack;
   logic [31:0] out_data;
   logic        out_wren;
   logic        out_full;

   modport master (
      input  cmd_data,
      input  cmd_empty,
      input  out_full,
      output cmd_ack,
      output out_data,
      output out_wren
   );

   modport slave (
      output cmd_data,
      output cmd_empty,
      output out_full,
      input  cmd_ack,
      input  out_data,
      input  out_wren
   );
endinterface

// File: rtl/pc_cmd_frame_gen.sv
// Pops 32-bit host commands and emits framed header/payload bursts or ping echoes
// into the host read FIFO, honouring its full flag and raising eof when a run ends.
module pc_cmd_frame_gen #(
   parameter logic [15:0] DEFAULT_LEN = 16'd4,
   parameter logic [7:0]  HDR_TAG     = 8'hA5
) (
   input  logic               bus_clk,
   input  logic               reset_n,
   pc_cmd_frame_gen_if.master bus,
   output logic               busy,
   output logic               eof,
   output logic [23:0]        frames_done,
   output logic [7:0]         bad_cmd_count
);
   typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, ECHO} state_t;

   localparam logic [3:0] OP_STOP    = 4'd0;
   localparam logic [3:0] OP_RUN     = 4'd1;
   localparam logic [3:0] OP_SET_LEN = 4'd2;
   localparam logic [3:0] OP_PING    = 4'd3;

   state_t      state, state_nxt;
   logic        ack_q, ack_nxt;
   logic [15:0] len_q, len_nxt;
   logic [27:0] frames_left, frames_left_nxt;
   logic [23:0] frame_idx, frame_idx_nxt;
   logic [15:0] word_idx, word_idx_nxt;
   logic [23:0] frames_done_nxt;
   logic [7:0]  bad_nxt;
   logic        eof_nxt;
   logic [27:0] echo_arg, echo_arg_nxt;
   logic [31:0] data;
   logic [3:0]  opcode;
   logic [27:0] arg;
   logic        take;
   logic        wr;
   logic        frame_end;

   assign opcode = bus.cmd_data[31:28];
   assign arg    = bus.cmd_data[27:0];
   assign wr     = (state != IDLE) && !bus.out_full;
   // A word is never examined in its own ack cycle, so one pop per fetch.
   assign take   = !bus.cmd_empty && !ack_q && ((state == IDLE) || (opcode == OP_STOP));

   assign bus.cmd_ack  = ack_q;
   assign bus.out_wren = wr;
   assign bus.out_data = data;
   assign busy         = (state != IDLE);

   always_ff @(posedge bus_clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         ack_q         <= 1'b0;
         len_q         <= DEFAULT_LEN;
         frames_left   <= '0;
         frame_idx     <= '0;
         word_idx      <= '0;
         frames_done   <= '0;
         bad_cmd_count <= '0;
         eof           <= 1'b0;
         echo_arg      <= '0;
      end else begin
         state         <= state_nxt;
         ack_q         <= ack_nxt;
         len_q         <= len_nxt;
         frames_left   <= frames_left_nxt;
         frame_idx     <= frame_idx_nxt;
         word_idx      <= word_idx_nxt;
         frames_done   <= frames_done_nxt;
         bad_cmd_count <= bad_nxt;
         eof           <= eof_nxt;
         echo_arg      <= echo_arg_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      ack_nxt         = take;
      len_nxt         = len_q;
      frames_left_nxt = frames_left;
      frame_idx_nxt   = frame_idx;
      word_idx_nxt    = word_idx;
      frames_done_nxt = frames_done;
      bad_nxt         = bad_cmd_count;
      eof_nxt         = eof;
      echo_arg_nxt    = echo_arg;
      frame_end       = 1'b0;

      // A STOP seen while busy wins over any frame completing in the same cycle.
      if (take && (state != IDLE)) begin
         state_nxt = IDLE;
         eof_nxt   = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (take) begin
                  case (opcode)
                     OP_STOP: ;
                     OP_RUN: begin
                        frames_left_nxt = arg;
                        frame_idx_nxt   = '0;
                        word_idx_nxt    = '0;
                        frames_done_nxt = '0;
                        if (arg == 28'd0) begin
                           eof_nxt = 1'b1;
                        end else begin
                           eof_nxt   = 1'b0;
                           state_nxt = HDR;
                        end
                     end
                     OP_SET_LEN: len_nxt = arg[15:0];
                     OP_PING: begin
                        echo_arg_nxt = arg;
                        state_nxt    = ECHO;
                     end
                     default: bad_nxt = (bad_cmd_count == 8'hFF) ? bad_cmd_count : bad_cmd_count + 8'd1;
                  endcase
               end
            end
            HDR: begin
               if (wr) begin
                  if (len_q == 16'd0) begin
                     frame_end = 1'b1;
                  end else begin
                     state_nxt    = PAYLOAD;
                     word_idx_nxt = '0;
                  end
               end
            end
            PAYLOAD: begin
               if (wr) begin
                  if (word_idx == len_q - 16'd1) frame_end = 1'b1;
                  else word_idx_nxt = word_idx + 16'd1;
               end
            end
            ECHO: begin
               if (wr) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase

         if (frame_end) begin
            frames_done_nxt = frames_done + 24'd1;
            frame_idx_nxt   = frame_idx + 24'd1;
            frames_left_nxt = frames_left - 28'd1;
            if (frames_left == 28'd1) begin
               state_nxt = IDLE;
               eof_nxt   = 1'b1;
            end else begin
               state_nxt = HDR;
            end
         end
      end
   end

   always_comb begin
      data = '0;
      case (state)
         HDR:     data = {HDR_TAG, frame_idx};
         PAYLOAD: data = {frame_idx[15:0], word_idx};
         ECHO:    data = {4'h3, echo_arg};
         default: data = '0;
      endcase
   end
endmodule

// File: tb/tb_pc_cmd_frame_gen.sv
// Directed bench for pc_cmd_frame_gen: a queue models the command FIFO, and every
// word accepted by the read FIFO is captured and compared with hand-computed frames.
module tb_pc_cmd_frame_gen;
   logic        bus_clk;
   logic        reset_n;
   logic        busy;
   logic        eof;
   logic [23:0] frames_done;
   logic [7:0]  bad_cmd_count;

   pc_cmd_frame_gen_if bus();

   pc_cmd_frame_gen dut (
      .bus_clk       (bus_clk),
      .reset_n       (reset_n),
      .bus           (bus),
      .busy          (busy),
      .eof           (eof),
      .frames_done   (frames_done),
      .bad_cmd_count (bad_cmd_count)
   );

   logic [31:0] cmd_q[$];
   logic [31:0] got[$];
   int          vec_count = 0;
   int          miss_count = 0;
   int          wr_full_viol = 0;
   int          ack_total = 0;
   int          ack_b2b = 0;
   int          pop_empty = 0;
   bit          last_ack = 0;
   bit          full_toggle = 0;
   bit          full_phase = 0;
   int          base_acks;
   int          got_at_reset;

   initial bus_clk = 1'b0;
   always #5 bus_clk = ~bus_clk;

   // FIFO-side model: inputs change on the falling edge, outputs are sampled 1 ns later.
   always @(negedge bus_clk) begin
      if (bus.cmd_ack === 1'b1) begin
         if (cmd_q.size() > 0) void'(cmd_q.pop_front());
         else pop_empty++;
         ack_total++;
         if (last_ack) ack_b2b++;
      end
      last_ack = (bus.cmd_ack === 1'b1);
      bus.cmd_empty = (cmd_q.size() == 0);
      bus.cmd_data  = (cmd_q.size() == 0) ? 32'h0 : cmd_q[0];
      full_phase    = full_toggle ? !full_phase : 1'b0;
      bus.out_full  = full_phase;
      #1;
      if (bus.out_wren === 1'b1) begin
         if (bus.out_full) wr_full_viol++;
         else got.push_back(bus.out_data);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vec_count++;
      if (observed !== expected) begin
         miss_count++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] word);
      cmd_q.push_back(word);
   endtask

   task automatic waitIdle(input int budget, input string tag);
      bit done;
      done = 1'b0;
      repeat (3) @(posedge bus_clk);
      #1;
      for (int n = 0; n < budget && !done; n++) begin
         if (cmd_q.size() == 0 && !busy && !bus.cmd_ack) done = 1'b1;
         else begin
            @(posedge bus_clk);
            #1;
         end
      end
      if (!done) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   function automatic logic [31:0] gotAt(input int i);
      return (i < got.size()) ? got[i] : 32'hDEADBEEF;
   endfunction

   logic [31:0] exp_run3 [9] = '{32'hA5000000, 32'h00000000, 32'h00000001,
                                 32'hA5000001, 32'h00010000, 32'h00010001,
                                 32'hA5000002, 32'h00020000, 32'h00020001};
   logic [31:0] exp_run1 [5] = '{32'hA5000000, 32'h00000000, 32'h00000001,
                                 32'h00000002, 32'h00000003};

   initial begin
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      @(posedge bus_clk);
      #1;
      checkOutput("rst_cmd_ack", {31'd0, bus.cmd_ack}, 32'd0);
      checkOutput("rst_out_wren", {31'd0, bus.out_wren}, 32'd0);
      checkOutput("rst_out_data", bus.out_data, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_eof", {31'd0, eof}, 32'd0);
      checkOutput("rst_frames_done", {8'd0, frames_done}, 32'd0);
      checkOutput("rst_bad_cmd", {24'd0, bad_cmd_count}, 32'd0);
      @(posedge bus_clk);
      #2 reset_n = 1'b1;

      // SET_LEN 2 then RUN 3, no backpressure
      @(posedge bus_clk);
      #1;
      got.delete();
      applyStimulus(32'h2000_0002);
      applyStimulus(32'h1000_0003);
      waitIdle(100, "run3");
      checkOutput("run3_count", got.size(), 32'd9);
      for (int i = 0; i < 9; i++) checkOutput($sformatf("run3_w%0d", i), gotAt(i), exp_run3[i]);
      checkOutput("run3_eof", {31'd0, eof}, 32'd1);
      checkOutput("run3_frames_done", {8'd0, frames_done}, 32'd3);
      checkOutput("run3_busy", {31'd0, busy}, 32'd0);

      // RUN 1 at length 4 with out_full toggling every cycle
      applyStimulus(32'h2000_0004);
      waitIdle(20, "setlen4");
      got.delete();
      wr_full_viol = 0;
      full_toggle  = 1'b1;
      applyStimulus(32'h1000_0001);
      waitIdle(100, "run1bp");
      full_toggle  = 1'b0;
      checkOutput("run1bp_count", got.size(), 32'd5);
      for (int i = 0; i < 5; i++) checkOutput($sformatf("run1bp_w%0d", i), gotAt(i), exp_run1[i]);
      checkOutput("run1bp_wr_while_full", wr_full_viol, 32'd0);
      checkOutput("run1bp_frames_done", {8'd0, frames_done}, 32'd1);

      // Fresh reset so eof starts low, then RUN 0 followed by PING
      @(posedge bus_clk);
      #2 reset_n = 1'b0;
      @(posedge bus_clk);
      #2 reset_n = 1'b1;
      @(posedge bus_clk);
      #1;
      checkOutput("ping_pre_eof", {31'd0, eof}, 32'd0);
      got.delete();
      ack_b2b   = 0;
      pop_empty = 0;
      base_acks = ack_total;
      applyStimulus(32'h1000_0000);
      applyStimulus(32'h30AB_CDEF);
      waitIdle(40, "ping");
      checkOutput("ping_count", got.size(), 32'd1);
      checkOutput("ping_word", gotAt(0), 32'h30ABCDEF);
      checkOutput("ping_eof", {31'd0, eof}, 32'd1);
      checkOutput("ping_pops", ack_total - base_acks, 32'd2);
      checkOutput("ping_b2b_acks", ack_b2b, 32'd0);

      // RUN 0x1000 with STOP right behind it
      got.delete();
      applyStimulus(32'h1000_1000);
      applyStimulus(32'h0000_0000);
      waitIdle(100, "stop");
      checkOutput("stop_count", got.size(), 32'd2);
      checkOutput("stop_w0", gotAt(0), 32'hA5000000);
      checkOutput("stop_w1", gotAt(1), 32'h00000000);
      checkOutput("stop_eof", {31'd0, eof}, 32'd1);
      checkOutput("stop_frames_done", {8'd0, frames_done}, 32'd0);

      // 300 unknown opcodes, alternating 0xF and 0x7
      got.delete();
      base_acks = ack_total;
      for (int i = 0; i < 300; i++) applyStimulus((i % 2 == 0) ? 32'hF000_0000 : 32'h7000_0001);
      waitIdle(800, "bad");
      checkOutput("bad_count", {24'd0, bad_cmd_count}, 32'd255);
      checkOutput("bad_pops", ack_total - base_acks, 32'd300);
      checkOutput("bad_writes", got.size(), 32'd0);
      checkOutput("bad_b2b_acks", ack_b2b, 32'd0);
      checkOutput("bad_pop_empty", pop_empty, 32'd0);

      // Reset asserted in the middle of RUN 5
      got.delete();
      applyStimulus(32'h1000_0005);
      repeat (8) @(posedge bus_clk);
      #2 reset_n = 1'b0;
      #1;
      got_at_reset = got.size();
      checkOutput("midrst_had_writes", {31'd0, got_at_reset > 0}, 32'd1);
      checkOutput("midrst_out_wren", {31'd0, bus.out_wren}, 32'd0);
      checkOutput("midrst_out_data", bus.out_data, 32'd0);
      checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
      checkOutput("midrst_cmd_ack", {31'd0, bus.cmd_ack}, 32'd0);
      checkOutput("midrst_eof", {31'd0, eof}, 32'd0);
      checkOutput("midrst_frames_done", {8'd0, frames_done}, 32'd0);
      repeat (3) @(posedge bus_clk);
      checkOutput("midrst_no_writes", got.size(), got_at_reset);
      #2 reset_n = 1'b1;
      @(posedge bus_clk);
      #1;
      got.delete();
      applyStimulus(32'h1000_0001);
      waitIdle(60, "postrst");
      checkOutput("postrst_count", got.size(), 32'd5);
      for (int i = 0; i < 5; i++) checkOutput($sformatf("postrst_w%0d", i), gotAt(i), exp_run1[i]);
      checkOutput("postrst_eof", {31'd0, eof}, 32'd1);
      checkOutput("postrst_frames_done", {8'd0, frames_done}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL global_timeout: got running, expected finished");
      $fatal(1, "[TB] simulation time limit reached");
   end
endmodule
